// File: rtl/riscv_pkg.sv
// Shared front-end definitions: fetch FSM states, reset PC default,
// instruction field positions and the base opcode map.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous circular FIFO with a same-edge flush; used for the
// instruction queue and for the in-order pc queue of in-flight requests.
module inst_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 pop_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH + 1)-1:0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clock) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches, queues in-order responses
// with their pcs for decode, and flushes/discards on redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = CW + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_discard_nxt;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_inst_valid;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_pc_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pc_full;
  logic          w_pc_empty;
  logic [31:0]   w_pc_head;
  logic [31:0]   w_redirect_pc;
  logic [SW-1:0] w_inflight;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_unused;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_inflight    = SW'(r_outstanding) + SW'(w_count);
  assign w_inst_valid  = !w_empty;
  assign w_push_entry  = '{pc: w_pc_head, inst: imem_rsp_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  // Redirect wins over any same-cycle handshake, push or pop.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding;
    w_discard_nxt     = r_discard;
    w_req_valid       = 1'b0;
    w_accept          = 1'b0;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_flush           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_req_valid = !redirect && (w_inflight < SW'(MAX_OUT));
        w_accept    = w_req_valid && imem_req_ready;
        if (redirect) begin
          w_flush           = 1'b1;
          w_fetch_pc_nxt    = w_redirect_pc;
          w_outstanding_nxt = '0;
          w_discard_nxt     = r_outstanding - CW'(imem_rsp_valid);
          if (r_outstanding != '0) w_state_nxt = ST_FLUSH;
        end else begin
          w_pop  = w_inst_valid && !stall;
          w_push = imem_rsp_valid;
          if (w_accept) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
        end
      end
      ST_FLUSH: begin
        if (imem_rsp_valid && (r_discard != '0)) w_discard_nxt = r_discard - CW'(1);
        if (redirect) w_fetch_pc_nxt = w_redirect_pc;
        if (w_discard_nxt == '0) w_state_nxt = ST_FETCH;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  inst_fifo #(.WIDTH(64), .DEPTH(MAX_OUT)) u_inst_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (w_flush),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Addresses of accepted requests, consumed in order by their responses.
  inst_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_pc_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (w_flush),
    .push      (w_accept),
    .push_data (r_fetch_pc),
    .pop       (w_push),
    .pop_data  (w_pc_head),
    .full      (w_pc_full),
    .empty     (w_pc_empty),
    .count     (w_pc_count)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = w_inst_valid;
  assign inst           = w_inst_valid ? w_head.inst : '0;
  assign inst_pc        = w_inst_valid ? w_head.pc : '0;
  assign opcode         = inst[OPCODE_MSB:OPCODE_LSB];
  assign funct3         = inst[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7         = inst[FUNCT7_MSB:FUNCT7_LSB];

  assign w_unused = &{1'b0, redirect_pc[1:0], w_full, w_pc_full, w_pc_empty, w_pc_count};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-level reference model checked every
// cycle, plus literal expectations for the reset, stall, backpressure,
// redirect, wrap and decode scenarios.
module tb_fetch_unit;

  localparam int unsigned MAX_OUT = 2;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_OUT(MAX_OUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rcyc  = 0;
  int lat   = 1;

  // Memory environment: pending request addresses and the cycle each answers.
  logic [31:0] mem_a[$];
  int          mem_d[$];

  // Reference model: decode queue of {pc,inst}, in-flight pcs, flush tracking.
  logic [63:0] m_q[$];
  logic [31:0] m_outq[$];
  bit          m_idle;
  bit          m_flush;
  int          m_disc;
  logic [31:0] m_pc;

  logic [31:0] acc_log[$];
  logic [31:0] acc_cyc[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'h40B5_0533 : (a ^ 32'h1357_9BDF);
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, rcyc);
    end
  endtask

  // One clock cycle: drive memory response, compare against the model,
  // then advance the model with this cycle's inputs.
  task automatic tick();
    bit          exp_rv;
    bit          acc_m;
    bit          rsp;
    logic [31:0] rdata;
    logic [31:0] exp_inst;
    logic [31:0] exp_ipc;
    logic [31:0] ent_pc;
    rcyc++;
    if (mem_a.size() > 0 && mem_d[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_a[0]);
      void'(mem_a.pop_front());
      void'(mem_d.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    exp_rv   = !m_idle && !m_flush && !redirect &&
               ((m_outq.size() + m_q.size()) < int'(MAX_OUT));
    exp_inst = (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0;
    exp_ipc  = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
    chk("inst", inst, exp_inst);
    chk("inst_pc", inst_pc, exp_ipc);
    chk("opcode", 32'(opcode), 32'(exp_inst[6:0]));
    chk("funct3", 32'(funct3), 32'(exp_inst[14:12]));
    chk("funct7", 32'(funct7), 32'(exp_inst[31:25]));

    if (imem_req_valid && imem_req_ready) begin
      mem_a.push_back(imem_req_addr);
      mem_d.push_back(cyc + lat);
      acc_log.push_back(imem_req_addr);
      acc_cyc.push_back(32'(rcyc));
    end
    if (inst_valid && !stall) pop_log.push_back(inst_pc);

    acc_m = exp_rv && imem_req_ready;
    rsp   = imem_rsp_valid;
    rdata = imem_rsp_data;
    @(posedge clock);
    cyc++;

    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_flush) begin
      if (rsp && m_disc > 0) m_disc--;
      if (m_disc == 0) m_flush = 1'b0;
      if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
    end else if (redirect) begin
      m_disc  = m_outq.size() - (rsp ? 1 : 0);
      m_flush = (m_outq.size() > 0);
      m_outq.delete();
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
      if (rsp) begin
        ent_pc = (m_outq.size() > 0) ? m_outq.pop_front() : 32'hDEAD_BEEF;
        m_q.push_back({ent_pc, rdata});
      end
      if (acc_m) begin
        m_outq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clock);
  endtask

  // Asserts reset from a negedge, checks the async clear, releases a cycle later.
  task automatic do_reset();
    reset          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fields", {15'h0, funct7, funct3, opcode}, 32'h0);
    mem_a.delete();
    mem_d.delete();
    m_q.delete();
    m_outq.delete();
    acc_log.delete();
    acc_cyc.delete();
    pop_log.delete();
    m_idle  = 1'b1;
    m_flush = 1'b0;
    m_disc  = 0;
    m_pc    = 32'h0000_0000;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    rcyc  = 0;
  endtask

  int n;

  initial begin
    reset          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    @(negedge clock);

    // Reset release with a 1-cycle memory.
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    repeat (8) tick();
    chk("t1_first_req_cycle", qget(acc_cyc, 0), 32'd2);
    chk("t1_addr0", qget(acc_log, 0), 32'h0);
    chk("t1_addr1", qget(acc_log, 1), 32'h4);
    chk("t1_addr2", qget(acc_log, 2), 32'h8);

    // Stall with two words queued, then drain one per cycle.
    do_reset();
    imem_req_ready = 1'b1;
    stall = 1'b1;
    repeat (8) tick();
    chk("t2_no_req", 32'(imem_req_valid), 32'h0);
    chk("t2_head_inst", inst, 32'h1357_9BDF);
    chk("t2_head_pc", inst_pc, 32'h0);
    stall = 1'b0;
    repeat (3) tick();
    chk("t2_pop0", qget(pop_log, 0), 32'h0);
    chk("t2_pop1", qget(pop_log, 1), 32'h4);

    // Backpressure: request held for 5 cycles, then accepted.
    do_reset();
    imem_req_ready = 1'b0;
    repeat (6) tick();
    chk("t3_valid_held", 32'(imem_req_valid), 32'h1);
    chk("t3_addr_held", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    chk("t3_next_addr", imem_req_addr, 32'h4);

    // Redirect with two outstanding requests on a slower memory.
    do_reset();
    lat = 3;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    n = acc_log.size();
    chk("t4_outstanding_before", 32'(n), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    repeat (10) tick();
    chk("t4_redir_addr", qget(acc_log, n), 32'h100);
    chk("t4_first_pc", qget(pop_log, 0), 32'h100);

    // Address wrap after redirect to the top word.
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    n = acc_log.size();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    chk("t5_wrap_a", qget(acc_log, n), 32'hFFFF_FFFC);
    chk("t5_wrap_b", qget(acc_log, n + 1), 32'h0);

    // Decode fields of 0x40B5_0533 fetched from 0x10.
    do_reset();
    imem_req_ready = 1'b1;
    stall = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0010;
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    chk("t6_inst", inst, 32'h40B5_0533);
    chk("t6_pc", inst_pc, 32'h10);
    chk("t6_opcode", 32'(opcode), 32'h33);
    chk("t6_funct3", 32'(funct3), 32'h0);
    chk("t6_funct7", 32'(funct7), 32'h20);

    // Final reset with a full queue exercises the mid-operation clear.
    do_reset();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUT, default 2, meaning the combined limit on outstanding memory requests plus queued instructions.
REQ-003 SHALL have one clock and an asynchronous active-low reset: `clock` in 1, the single clock (all state on rising edge); `reset` in 1, asynchronous, active-low.
REQ-004 SHALL have the following memory-request ports:
- imem_req_valid  out  1: fetch request valid.
- imem_req_ready  in  1: memory accepts the request.
- imem_req_addr  out  32: word-aligned fetch address.
REQ-005 SHALL have the following memory-response ports:
- imem_rsp_valid  in  1: response beat, in request order, never back-pressured.
- imem_rsp_data  in  32: fetched instruction word.
REQ-006 SHALL have the following redirect ports:
- redirect  in  1: taken branch or jump; flush and restart.
- redirect_pc  in  32: restart address.
REQ-007 SHALL have the following decode-side ports:
- stall  in  1: decode not consuming this cycle.
- inst_valid  out  1: head instruction present.
- inst  out  32: head instruction word.
- inst_pc  out  32: address of the head instruction.
REQ-008 SHALL have the following decoded-field ports, all combinational slices of inst:
- opcode  out  7: inst[6:0].
- funct3  out  3: inst[14:12].
- funct7  out  7: inst[31:25].

Function
REQ-009 SHALL implement FSM states IDLE, FETCH and FLUSH.
- IDLE lasts exactly one cycle after reset deassertion, then moves to FETCH.
- FETCH -> FLUSH on redirect while outstanding>0.
- FETCH -> FETCH (restarted) on redirect while outstanding==0.
- FLUSH -> FETCH when the discard count reaches 0.
REQ-010 SHALL assert imem_req_valid only in FETCH, and only when outstanding + queue_count < MAX_OUT and redirect==0.
REQ-011 SHALL treat a request as accepted when imem_req_valid && imem_req_ready; fetch_pc then increments by 4 (mod 2^32, wrapping from 32'hFFFF_FFFC to 0) and outstanding increments.
REQ-012 SHALL hold imem_req_addr and imem_req_valid stable while valid && !ready, unless redirect occurs.
REQ-013 SHALL, on each imem_rsp_valid in FETCH, push {data, pc} into a MAX_OUT-entry FIFO and decrement outstanding; the pc comes from a parallel in-order pc FIFO.
REQ-014 SHALL pop the FIFO head when inst_valid && !stall; a push and pop in the same cycle SHALL keep queue_count unchanged.
REQ-015 SHALL use a response-to-inst_valid latency of 1 cycle when the queue is empty; there is no combinational bypass.
REQ-016 SHALL handle redirect as follows: the FIFO is emptied the same edge, fetch_pc <= {redirect_pc[31:2],2'b00}, discard count <= outstanding (minus 1 if a response arrives that cycle), and inst_valid is 0 next cycle.
REQ-017 SHALL, in FLUSH, drop responses without pushing, decrement discard count, and issue no requests.
REQ-018 SHALL let redirect take priority over a simultaneous request handshake, pop or push; the simultaneous request is not counted as accepted.
REQ-019 SHALL, on a redirect while in FLUSH, retarget fetch_pc while keeping the discard count.
REQ-020 SHALL never overflow the FIFO; outstanding + queue_count <= MAX_OUT at all times.

Reset
REQ-021 SHALL, while reset==0, immediately force: state=IDLE, fetch_pc=RESET_PC, outstanding=0, discard=0, queue_count=0, imem_req_valid=0, inst_valid=0; inst, inst_pc, opcode, funct3 and funct7 read 0.
REQ-022 SHALL abandon in-flight responses on reset mid-operation; the memory is reset together with the block.

Structure
REQ-023 SHALL place the FSM state enum, the RESET_PC default and the opcode/funct field bit positions in the shared package riscv_pkg, alongside the opcode enum used by controller.
REQ-024 SHALL use one sub-module, inst_fifo, a parameterised synchronous FIFO of width 64 ({pc,inst}) and depth MAX_OUT with push, pop, full, empty and count.

Verification
REQ-025 SHALL pass the reset-release test: release reset with ready=1 and 1-cycle memory -> first request addr 0x0 in cycle 2 (IDLE is cycle 1), then 0x4 and 0x8 as slots free.
REQ-026 SHALL pass the backpressure test: ready=0 for 5 cycles -> imem_req_addr stays 0x0 and valid stays high; with ready=1 the next accept moves the address to 0x4.
REQ-027 SHALL pass the stall test: stall=1 with 2 words queued -> no new requests, inst=first word, inst_pc=0x0 held; releasing stall pops one word per cycle.
REQ-028 SHALL pass the redirect-with-outstanding test: redirect to 0x103 with 2 outstanding -> next addr 0x100, both old responses dropped, first inst_pc after redirect is 0x100.
REQ-029 SHALL pass the wrap test: redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0.
REQ-030 SHALL pass the decode-field test: word 0x40B5_0533 fetched -> opcode=7'b0110011, funct3=3'b000, funct7=7'b0100000.
